// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo back-end types: operand/tag widths, the ALU issue-queue entry
// and the CDB capture rule every reservation station applies.
package tomasulo_pkg;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] op1_data;
      logic [DATA_W-1:0] op2_data;
      logic [TAG_W-1:0]  op1_tag;
      logic [TAG_W-1:0]  op2_tag;
      logic              op1_rdy;
      logic              op2_rdy;
      logic [TAG_W-1:0]  rd_tag;
      logic [2:0]        funct3;
      logic [2:0]        alu_ext;
   } alu_iq_entry_t;

   // A live entry picks up a broadcast for any operand still waiting on that tag.
   function automatic alu_iq_entry_t cdb_capture(input alu_iq_entry_t e,
                                                 input logic bus_valid,
                                                 input logic [TAG_W-1:0] bus_tag,
                                                 input logic [DATA_W-1:0] bus_data);
      alu_iq_entry_t r;
      r = e;
      if (e.valid && bus_valid) begin
         if (!e.op1_rdy && e.op1_tag == bus_tag) begin
            r.op1_data = bus_data;
            r.op1_rdy  = 1'b1;
         end
         if (!e.op2_rdy && e.op2_tag == bus_tag) begin
            r.op2_data = bus_data;
            r.op2_rdy  = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cdb_if.sv
// Common data bus: one result broadcast per cycle, tagged with its producer.
interface cdb_if;
   import tomasulo_pkg::*;

   logic [DATA_W-1:0] data;
   logic [TAG_W-1:0]  tag;
   logic              valid;

   modport source (output data, tag, valid);
   modport sink   (input  data, tag, valid);
endinterface

// File: rtl/iq_oldest_ready_select.sv
// Priority pick of the lowest-index requester; in an age-ordered queue that is
// the oldest ready entry. Shared by the ALU/AGU/mul/div issue queues.
module iq_oldest_ready_select #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic         any
);

   // Isolate the lowest set bit.
   assign grant = req & (~req + N'(1));
   assign any   = |req;

endmodule

// File: rtl/alu_issue_queue.sv
// Integer-ALU reservation station: age-ordered shift queue with CDB wakeup,
// oldest-ready issue over valid/ready and a full flag back to dispatch.
module alu_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     queue_alu_en,
   input  logic [DATA_W-1:0]        queue_op1_data,
   input  logic [TAG_W-1:0]         queue_op1_tag,
   input  logic                     queue_op1_data_valid,
   input  logic [DATA_W-1:0]        queue_op2_data,
   input  logic [TAG_W-1:0]         queue_op2_tag,
   input  logic                     queue_op2_data_valid,
   input  logic [TAG_W-1:0]         queue_rd_tag,
   input  logic [2:0]               queue_funct3,
   input  logic [2:0]               queue_alu_ext,
   cdb_if.sink                      cdb,
   input  logic                     flush,
   output logic                     queue_alu_full,
   output logic [$clog2(DEPTH):0]   entry_count,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [DATA_W-1:0]        issue_op1_data,
   output logic [DATA_W-1:0]        issue_op2_data,
   output logic [TAG_W-1:0]         issue_rd_tag,
   output logic [2:0]               issue_funct3,
   output logic [2:0]               issue_alu_ext
);
   import tomasulo_pkg::alu_iq_entry_t;
   import tomasulo_pkg::cdb_capture;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);

   alu_iq_entry_t    q   [DEPTH];
   alu_iq_entry_t    up  [DEPTH];
   alu_iq_entry_t    nxt [DEPTH];
   alu_iq_entry_t    new_e;
   alu_iq_entry_t    sel_e;
   logic [CW-1:0]    cnt;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] grant;
   logic             any;
   logic             fire;
   logic             wr;
   logic [IW-1:0]    wr_idx;
   logic             shift_on;

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         rdy[i] = q[i].valid & q[i].op1_rdy & q[i].op2_rdy;
   end

   iq_oldest_ready_select #(.N(DEPTH)) u_select (
      .req   (rdy),
      .grant (grant),
      .any   (any)
   );

   assign queue_alu_full = (cnt == CW'(DEPTH));
   assign entry_count    = cnt;
   assign fire           = any & issue_ready;
   assign wr             = queue_alu_en & ~queue_alu_full;
   assign wr_idx         = IW'(cnt - CW'(fire));

   always_comb begin
      sel_e = '0;
      for (int i = 0; i < DEPTH; i++)
         if (grant[i]) sel_e = q[i];
   end

   assign issue_valid    = any;
   assign issue_op1_data = sel_e.op1_data;
   assign issue_op2_data = sel_e.op2_data;
   assign issue_rd_tag   = sel_e.rd_tag;
   assign issue_funct3   = sel_e.funct3;
   assign issue_alu_ext  = sel_e.alu_ext;

   // Incoming entry, with same-cycle CDB bypass for operands not yet valid.
   always_comb begin
      new_e          = '0;
      new_e.valid    = 1'b1;
      new_e.op1_data = queue_op1_data;
      new_e.op1_tag  = queue_op1_tag;
      new_e.op1_rdy  = queue_op1_data_valid;
      new_e.op2_data = queue_op2_data;
      new_e.op2_tag  = queue_op2_tag;
      new_e.op2_rdy  = queue_op2_data_valid;
      new_e.rd_tag   = queue_rd_tag;
      new_e.funct3   = queue_funct3;
      new_e.alu_ext  = queue_alu_ext;
      new_e          = cdb_capture(new_e, cdb.valid, cdb.tag, cdb.data);
   end

   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++)
         up[i] = q[i + 1];
      up[DEPTH-1] = '0;
   end

   // Slots at and above the issued one take their upper neighbour; snoop
   // applies to whatever lands in each slot.
   always_comb begin
      shift_on = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         shift_on = shift_on | (fire & grant[i]);
         nxt[i]   = cdb_capture(shift_on ? up[i] : q[i], cdb.valid, cdb.tag, cdb.data);
      end
      if (wr) nxt[wr_idx] = new_e;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else begin
         cnt <= cnt + CW'(wr) - CW'(fire);
         for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed + randomized bench for alu_issue_queue against a queue-based model.
module tb_alu_issue_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, queue_alu_en, flush, issue_ready;
   logic [31:0] queue_op1_data, queue_op2_data;
   logic [5:0]  queue_op1_tag, queue_op2_tag, queue_rd_tag;
   logic        queue_op1_data_valid, queue_op2_data_valid;
   logic [2:0]  queue_funct3, queue_alu_ext;
   logic        queue_alu_full, issue_valid;
   logic [2:0]  entry_count;
   logic [31:0] issue_op1_data, issue_op2_data;
   logic [5:0]  issue_rd_tag;
   logic [2:0]  issue_funct3, issue_alu_ext;

   cdb_if cdb_bus ();

   alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(6)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .queue_alu_en         (queue_alu_en),
      .queue_op1_data       (queue_op1_data),
      .queue_op1_tag        (queue_op1_tag),
      .queue_op1_data_valid (queue_op1_data_valid),
      .queue_op2_data       (queue_op2_data),
      .queue_op2_tag        (queue_op2_tag),
      .queue_op2_data_valid (queue_op2_data_valid),
      .queue_rd_tag         (queue_rd_tag),
      .queue_funct3         (queue_funct3),
      .queue_alu_ext        (queue_alu_ext),
      .cdb                  (cdb_bus),
      .flush                (flush),
      .queue_alu_full       (queue_alu_full),
      .entry_count          (entry_count),
      .issue_valid          (issue_valid),
      .issue_ready          (issue_ready),
      .issue_op1_data       (issue_op1_data),
      .issue_op2_data       (issue_op2_data),
      .issue_rd_tag         (issue_rd_tag),
      .issue_funct3         (issue_funct3),
      .issue_alu_ext        (issue_alu_ext)
   );

   typedef struct {
      logic [31:0] d1, d2;
      logic [5:0]  t1, t2, rd;
      logic        r1, r2;
      logic [2:0]  f3, ext;
   } ment_t;

   ment_t mq[$];
   int    vectors = 0;
   int    miscompares = 0;
   bit    chk_en = 1'b0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic int m_sel();
      foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
      return -1;
   endfunction

   function automatic ment_t wake(ment_t e);
      if (cdb_bus.valid) begin
         if (!e.r1 && e.t1 == cdb_bus.tag) begin e.d1 = cdb_bus.data; e.r1 = 1'b1; end
         if (!e.r2 && e.t2 == cdb_bus.tag) begin e.d2 = cdb_bus.data; e.r2 = 1'b1; end
      end
      return e;
   endfunction

   // One clock edge of the reference: issue, wakeup, then append.
   function automatic void model_step();
      int    s;
      bit    full;
      ment_t n;
      if (!rst || flush) begin
         mq.delete();
         return;
      end
      s    = m_sel();
      full = (mq.size() == DEPTH);
      if (s >= 0 && issue_ready) mq.delete(s);
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (queue_alu_en && !full) begin
         n.d1 = queue_op1_data; n.t1 = queue_op1_tag; n.r1 = queue_op1_data_valid;
         n.d2 = queue_op2_data; n.t2 = queue_op2_tag; n.r2 = queue_op2_data_valid;
         n.rd = queue_rd_tag;   n.f3 = queue_funct3;  n.ext = queue_alu_ext;
         mq.push_back(wake(n));
      end
   endfunction

   always @(negedge clk) begin
      int s;
      if (chk_en) begin
         s = m_sel();
         chk("count", 64'(entry_count), 64'(mq.size()));
         chk("full", 64'(queue_alu_full), 64'(mq.size() == DEPTH));
         chk("issue_valid", 64'(issue_valid), 64'(s >= 0));
         if (s >= 0) begin
            chk("op1", 64'(issue_op1_data), 64'(mq[s].d1));
            chk("op2", 64'(issue_op2_data), 64'(mq[s].d2));
            chk("rd_tag", 64'(issue_rd_tag), 64'(mq[s].rd));
            chk("funct3", 64'(issue_funct3), 64'(mq[s].f3));
            chk("alu_ext", 64'(issue_alu_ext), 64'(mq[s].ext));
         end else begin
            chk("idle_bus", {issue_op1_data, issue_op2_data}, 64'(0));
            chk("idle_ctl", 64'({issue_rd_tag, issue_funct3, issue_alu_ext}), 64'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      rst = 1'b1; flush = 1'b0; queue_alu_en = 1'b0;
      cdb_bus.valid = 1'b0; cdb_bus.tag = '0; cdb_bus.data = '0;
   endtask

   task automatic disp(input logic [31:0] d1, input logic v1, input logic [5:0] t1,
                       input logic [31:0] d2, input logic v2, input logic [5:0] t2,
                       input logic [5:0] rd, input logic [2:0] f3);
      queue_alu_en = 1'b1;
      queue_op1_data = d1; queue_op1_data_valid = v1; queue_op1_tag = t1;
      queue_op2_data = d2; queue_op2_data_valid = v2; queue_op2_tag = t2;
      queue_rd_tag = rd; queue_funct3 = f3; queue_alu_ext = f3 ^ rd[2:0];
   endtask

   task automatic bcast(input logic [5:0] t, input logic [31:0] d);
      cdb_bus.valid = 1'b1; cdb_bus.tag = t; cdb_bus.data = d;
   endtask

   initial begin
      idle();
      issue_ready = 1'b0;
      disp('0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
      queue_alu_en = 1'b0;
      rst = 1'b0;
      tick(); tick();
      chk("rst_count", 64'(entry_count), 64'd0);
      chk("rst_full", 64'(queue_alu_full), 64'd0);
      chk("rst_valid", 64'(issue_valid), 64'd0);
      chk("rst_data", {issue_op1_data, issue_op2_data}, 64'd0);
      idle();
      chk_en = 1'b1;

      // Ready-operand dispatch
      issue_ready = 1'b1;
      disp(32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd12, 3'd0);
      tick(); idle();
      chk("t1_valid", 64'(issue_valid), 64'd1);
      chk("t1_op1", 64'(issue_op1_data), 64'd5);
      chk("t1_op2", 64'(issue_op2_data), 64'd7);
      chk("t1_rd", 64'(issue_rd_tag), 64'd12);
      tick();
      chk("t1_count", 64'(entry_count), 64'd0);

      // CDB wakeup on tag 0
      disp(32'd0, 1'b0, 6'd0, 32'd3, 1'b1, 6'd0, 6'd13, 3'd1);
      tick(); idle();
      chk("t2_wait0", 64'(issue_valid), 64'd0);
      tick();
      bcast(6'd0, 32'd1);
      chk("t2_wait1", 64'(issue_valid), 64'd0);
      tick(); idle();
      chk("t2_valid", 64'(issue_valid), 64'd1);
      chk("t2_op1", 64'(issue_op1_data), 64'd1);
      chk("t2_op2", 64'(issue_op2_data), 64'd3);
      tick();

      // Same-cycle bypass
      disp(32'd2, 1'b1, 6'd0, 32'd0, 1'b0, 6'd9, 6'd14, 3'd2);
      bcast(6'd9, 32'h24);
      tick(); idle();
      chk("t3_valid", 64'(issue_valid), 64'd1);
      chk("t3_op2", 64'(issue_op2_data), 64'h24);
      tick();

      // Fill to full, drop the fifth, then flush
      issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         disp(32'(k), 1'b0, 6'(20 + k), 32'(k), 1'b1, 6'd0, 6'(20 + k), 3'd3);
         tick();
      end
      idle();
      chk("t4_full", 64'(queue_alu_full), 64'd1);
      chk("t4_count", 64'(entry_count), 64'd4);
      disp(32'd9, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd30, 3'd4);
      tick(); idle();
      chk("t4_drop_count", 64'(entry_count), 64'd4);
      chk("t4_drop_valid", 64'(issue_valid), 64'd0);
      bcast(6'd20, 32'h77);
      tick(); idle();
      chk("t4_wake_rd", 64'(issue_rd_tag), 64'd20);
      chk("t4_wake_op1", 64'(issue_op1_data), 64'h77);
      issue_ready = 1'b1;
      tick();
      chk("t4_after_issue", 64'(entry_count), 64'd3);
      flush = 1'b1;
      tick(); idle();
      chk("t4_flush_count", 64'(entry_count), 64'd0);
      chk("t4_flush_full", 64'(queue_alu_full), 64'd0);
      bcast(6'd21, 32'd5);
      tick(); idle();
      chk("t4_no_resurrect", 64'({issue_valid, entry_count}), 64'd0);

      // Out-of-order issue past a waiting older entry
      issue_ready = 1'b0;
      disp(32'd0, 1'b0, 6'd3, 32'd1, 1'b1, 6'd0, 6'd1, 3'd5); tick();
      disp(32'd2, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd2, 3'd6); tick();
      disp(32'd3, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 6'd3, 3'd7); tick();
      idle();
      chk("t5_first", 64'(issue_rd_tag), 64'd2);
      issue_ready = 1'b1;
      tick();
      chk("t5_second", 64'(issue_rd_tag), 64'd3);
      chk("t5_count", 64'(entry_count), 64'd2);
      tick();
      chk("t5_a_waits", 64'({issue_valid, entry_count}), 64'd1);
      bcast(6'd3, 32'h55);
      tick(); idle();
      chk("t5_a_rd", 64'(issue_rd_tag), 64'd1);
      chk("t5_a_op1", 64'(issue_op1_data), 64'h55);
      tick();

      // Reset mid-operation
      issue_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(32'(k), 1'b0, 6'(40 + k), 32'd0, 1'b1, 6'd0, 6'(40 + k), 3'd1);
         tick();
      end
      idle();
      rst = 1'b0;
      tick(); idle();
      chk("t6_rst", 64'({queue_alu_full, issue_valid, entry_count}), 64'd0);
      bcast(6'd40, 32'd1);
      tick(); idle();
      chk("t6_no_resurrect", 64'({issue_valid, entry_count}), 64'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         queue_alu_en         = ($urandom_range(0, 1) == 1);
         queue_op1_data       = $urandom;
         queue_op2_data       = $urandom;
         queue_op1_tag        = 6'($urandom_range(0, 7));
         queue_op2_tag        = 6'($urandom_range(0, 7));
         queue_op1_data_valid = ($urandom_range(0, 2) == 0);
         queue_op2_data_valid = ($urandom_range(0, 2) == 0);
         queue_rd_tag         = 6'($urandom_range(0, 63));
         queue_funct3         = 3'($urandom_range(0, 7));
         queue_alu_ext        = 3'($urandom_range(0, 7));
         cdb_bus.valid        = ($urandom_range(0, 1) == 1);
         cdb_bus.tag          = 6'($urandom_range(0, 7));
         cdb_bus.data         = $urandom;
         flush                = ($urandom_range(0, 49) == 0);
         rst                  = ($urandom_range(0, 99) != 0);
         issue_ready          = ($urandom_range(0, 9) < 6);
         tick();
      end
      idle();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
